// File: rtl/router_pkg.sv
// Shared constants and helpers for the router write-side synchroniser.
package router_pkg;

  localparam int ROUTER_MAX_CH      = 16;
  localparam int ROUTER_TIMEOUT_DEF = 30;

  // Returns a one-hot select for idx, or all zeros when the address is not valid.
  function automatic logic [ROUTER_MAX_CH-1:0] onehot(input int unsigned idx, input logic valid);
    onehot = '0;
    if (valid && (idx < ROUTER_MAX_CH)) onehot[idx[3:0]] = 1'b1;
  endfunction

endpackage

// File: rtl/router_sync_wdog.sv
// One channel's read-timeout watchdog: counts valid-but-unread cycles and
// emits a one-cycle soft_reset pulse when the window expires.
module router_sync_wdog
  import router_pkg::*;
#(
  parameter int TIMEOUT = ROUTER_TIMEOUT_DEF,
  localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_vld,
  input  logic i_rd,
  output logic o_soft_reset
);

  logic [TMR_W-1:0] r_tmr;
  logic             r_soft_reset;

  // Timer and pulse update; an empty FIFO or a read restarts the window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmr        <= '0;
      r_soft_reset <= 1'b0;
    end else if (!i_vld || i_rd) begin
      r_tmr        <= '0;
      r_soft_reset <= 1'b0;
    end else if (r_tmr == TMR_W'(TIMEOUT - 1)) begin
      r_tmr        <= '0;
      r_soft_reset <= 1'b1;
    end else begin
      r_tmr        <= r_tmr + 1'b1;
      r_soft_reset <= 1'b0;
    end
  end

  assign o_soft_reset = r_soft_reset;

endmodule

// File: rtl/router_sync_n.sv
// Write-side synchroniser for the N-port router: latches the header address,
// steers the payload write strobe, muxes back the addressed full flag and
// runs one read-timeout watchdog per output FIFO.
// Optional: define SYNC_TMO_CNT_EN to add per-channel saturating counts of
// soft_reset pulses on tmo_count.
module router_sync_n
  import router_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = ROUTER_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] din,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] read_enb,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] full,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] soft_reset,
`ifdef SYNC_TMO_CNT_EN
  output logic [NUM_CH*8-1:0] tmo_count,
`endif
  output logic              addr_err
);

  logic [ADDR_W-1:0] r_int_addr;
  logic              r_addr_err;
  logic [NUM_CH-1:0] w_sel;

  // Capture the destination on the header strobe; flag channels that do not exist.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_int_addr <= '0;
      r_addr_err <= 1'b0;
    end else if (detect_add) begin
      r_int_addr <= din;
      r_addr_err <= (32'(din) >= NUM_CH);
    end
  end

  // Select vector follows the latched address, so a same-cycle header uses the old one.
  assign w_sel     = NUM_CH'(onehot(32'(r_int_addr), !r_addr_err));
  assign write_enb = write_enb_reg ? w_sel : '0;
  assign fifo_full = |(full & w_sel);
  assign vld_out   = ~empty;
  assign addr_err  = r_addr_err;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      router_sync_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk          (clk),
        .reset        (reset),
        .i_vld        (vld_out[gi]),
        .i_rd         (read_enb[gi]),
        .o_soft_reset (soft_reset[gi])
      );

`ifdef SYNC_TMO_CNT_EN
      logic [7:0] r_cnt;

      // Saturating count of flushes issued on this channel.
      always_ff @(posedge clk) begin
        if (reset)                              r_cnt <= '0;
        else if (soft_reset[gi] && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
      end

      assign tmo_count[gi*8 +: 8] = r_cnt;
`endif
    end
  endgenerate

endmodule
